// File: rtl/smem_arbiter.sv
// smem_arbiter: owner of the single-port signature SRAM, shared between the
// internal signature logger and the external scan port.
//
// Ports
//   i_clk, i_reset         core clock, asynchronous active-high reset
//   i_smem_ext             1 = external port owns the SRAM, 0 = logger owns it
//   i_smem_cen/wen/addr/wdata  external access (active-low enables)
//   o_smem_rdata           external read data, held between reads
//   o_ext_grant            external accesses are being honoured
//   i_log_valid/data       logger word (held by the logger until accepted)
//   o_log_ready            logger word accepted when valid & ready
//   i_log_clear            rewind the write pointer (LOG state only)
//   o_log_full/count       logging progress since reset/clear
//   o_mem_*                SRAM pins (active-low enables)
//   i_mem_rdata            SRAM Q, valid one cycle after a read
module smem_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_smem_ext,
  input  logic              i_smem_cen,
  input  logic              i_smem_wen,
  input  logic [ADDR_W-1:0] i_smem_addr,
  input  logic [DATA_W-1:0] i_smem_wdata,
  output logic [DATA_W-1:0] o_smem_rdata,
  output logic              o_ext_grant,
  input  logic              i_log_valid,
  input  logic [DATA_W-1:0] i_log_data,
  output logic              o_log_ready,
  input  logic              i_log_clear,
  output logic              o_log_full,
  output logic [ADDR_W:0]   o_log_count,
  output logic              o_mem_cen,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_LOG  = 2'd0,
    ST_TURN = 2'd1,
    ST_EXT  = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wptr;
  logic [ADDR_W:0]     r_count;
  logic                r_full;
  logic                r_rd_pend;
  logic [DATA_W-1:0]   r_rdata_hold;

  logic                w_in_log;
  logic                w_in_ext;
  logic                w_log_ready;
  logic                w_log_wr;
  logic                w_log_clr;
  logic                w_ext_rd;

  assign w_in_log = (r_state == ST_LOG);
  assign w_in_ext = (r_state == ST_EXT);

  // Reset gates ready directly so no logger write can leak out while
  // i_reset is held, even though the state already reads LOG.
  assign w_log_clr   = w_in_log & i_log_clear;
  assign w_log_ready = ~i_reset & w_in_log & ~r_full & ~i_log_clear;
  assign w_log_wr    = i_log_valid & w_log_ready;
  assign w_ext_rd    = w_in_ext & ~i_smem_cen & i_smem_wen;

  assign o_log_ready = w_log_ready;
  assign o_ext_grant = w_in_ext;
  assign o_log_full  = r_full;
  assign o_log_count = r_count;

  // Read data is forwarded straight from the SRAM in the cycle after the
  // read, then served from the hold register until the next read lands.
  assign o_smem_rdata = r_rd_pend ? i_mem_rdata : r_rdata_hold;

  // SRAM pins: no register on the request path.
  always_comb begin
    o_mem_cen   = 1'b1;
    o_mem_wen   = 1'b1;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_in_ext) begin
      o_mem_cen   = i_smem_cen;
      o_mem_wen   = i_smem_wen;
      o_mem_addr  = i_smem_addr;
      o_mem_wdata = i_smem_wdata;
    end else if (w_log_wr) begin
      o_mem_cen   = 1'b0;
      o_mem_wen   = 1'b0;
      o_mem_addr  = r_wptr;
      o_mem_wdata = i_log_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_LOG;
      r_wptr       <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_rdata_hold <= '0;
    end else begin
      case (r_state)
        ST_LOG:  if (i_smem_ext) r_state <= ST_TURN;
        ST_TURN: r_state <= i_smem_ext ? ST_EXT : ST_LOG;
        ST_EXT:  if (!i_smem_ext) r_state <= ST_TURN;
        default: r_state <= ST_LOG;
      endcase

      if (w_log_clr) begin
        r_wptr  <= '0;
        r_count <= '0;
        r_full  <= 1'b0;
      end else if (w_log_wr) begin
        r_count <= r_count + 1'b1;
        if (r_count == LAST_COUNT) begin
          r_full <= 1'b1;
        end
        r_wptr <= (r_wptr == LAST_ADDR) ? '0 : r_wptr + 1'b1;
      end

      // Pending read completes regardless of state, so a read issued in
      // the last EXT cycle is still captured during TURN.
      r_rd_pend <= w_ext_rd;
      if (r_rd_pend) begin
        r_rdata_hold <= i_mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_smem_arbiter.sv
module tb_smem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        smem_ext, smem_cen, smem_wen;
  logic [11:0] smem_addr;
  logic [15:0] smem_wdata, smem_rdata;
  logic        ext_grant;
  logic        log_valid, log_ready, log_clear, log_full;
  logic [15:0] log_data;
  logic [12:0] log_count;
  logic        mem_cen, mem_wen;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] sram [4096];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  smem_arbiter #(.ADDR_W(12), .DATA_W(16), .DEPTH(4096)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_smem_ext(smem_ext), .i_smem_cen(smem_cen), .i_smem_wen(smem_wen),
    .i_smem_addr(smem_addr), .i_smem_wdata(smem_wdata),
    .o_smem_rdata(smem_rdata), .o_ext_grant(ext_grant),
    .i_log_valid(log_valid), .i_log_data(log_data), .o_log_ready(log_ready),
    .i_log_clear(log_clear), .o_log_full(log_full), .o_log_count(log_count),
    .o_mem_cen(mem_cen), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // Behavioural single-port SRAM, Q valid one cycle after a read.
  always @(posedge clk) begin
    if (!mem_cen) begin
      if (!mem_wen) sram[mem_addr] <= mem_wdata;
      else          mem_rdata <= sram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ext, cen, wen;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic        lv;
    logic [15:0] ld;
    logic        clr;
    logic        e_ready, e_grant, e_mcen, e_mwen;
    logic [11:0] e_maddr;
    logic [15:0] e_mwdata;
    logic [12:0] e_count;
    logic        chk_rd;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(
    logic ext, logic cen, logic wen, logic [11:0] addr, logic [15:0] wdata,
    logic lv, logic [15:0] ld, logic clr,
    logic e_ready, logic e_grant, logic e_mcen, logic e_mwen,
    logic [11:0] e_maddr, logic [15:0] e_mwdata, logic [12:0] e_count,
    logic chk_rd, logic [15:0] e_rdata);
    vec_t v;
    v.ext = ext; v.cen = cen; v.wen = wen; v.addr = addr; v.wdata = wdata;
    v.lv = lv; v.ld = ld; v.clr = clr;
    v.e_ready = e_ready; v.e_grant = e_grant; v.e_mcen = e_mcen; v.e_mwen = e_mwen;
    v.e_maddr = e_maddr; v.e_mwdata = e_mwdata; v.e_count = e_count;
    v.chk_rd = chk_rd; v.e_rdata = e_rdata;
    return v;
  endfunction

  initial begin
    // Continues from the end of the read sweep (EXT, full, last read of 4095 pending).
    //            ext cen wen addr   wdata     lv ld        clr  rdy gnt cen wen maddr  mwdata    count chk rdata
    tbl[0]  = mk(1, 1, 1, 12'd0, 16'h0000, 0, 16'h0000, 0,   0, 1, 1, 1, 12'd0, 16'h0000, 13'd4096, 1, 16'hAA5A);
    tbl[1]  = mk(1, 1, 1, 12'd0, 16'h0000, 0, 16'h0000, 0,   0, 1, 1, 1, 12'd0, 16'h0000, 13'd4096, 1, 16'hAA5A);
    tbl[2]  = mk(1, 0, 0, 12'd7, 16'hBEEF, 0, 16'h0000, 0,   0, 1, 0, 0, 12'd7, 16'hBEEF, 13'd4096, 1, 16'hAA5A);
    tbl[3]  = mk(0, 0, 1, 12'd7, 16'h0000, 0, 16'h0000, 0,   0, 1, 0, 1, 12'd7, 16'h0000, 13'd4096, 1, 16'hAA5A);
    tbl[4]  = mk(0, 0, 1, 12'd3, 16'h0000, 0, 16'h0000, 0,   0, 0, 1, 1, 12'd0, 16'h0000, 13'd4096, 1, 16'hBEEF);
    tbl[5]  = mk(0, 1, 1, 12'd0, 16'h0000, 1, 16'h1234, 1,   0, 0, 1, 1, 12'd0, 16'h0000, 13'd4096, 1, 16'hBEEF);
    tbl[6]  = mk(0, 1, 1, 12'd0, 16'h0000, 1, 16'h1000, 0,   1, 0, 0, 0, 12'd0, 16'h1000, 13'd0,    1, 16'hBEEF);
    tbl[7]  = mk(0, 1, 1, 12'd0, 16'h0000, 1, 16'h1001, 0,   1, 0, 0, 0, 12'd1, 16'h1001, 13'd1,    1, 16'hBEEF);
    tbl[8]  = mk(0, 1, 1, 12'd0, 16'h0000, 1, 16'h1002, 0,   1, 0, 0, 0, 12'd2, 16'h1002, 13'd2,    1, 16'hBEEF);
    tbl[9]  = mk(0, 1, 1, 12'd0, 16'h0000, 1, 16'h1003, 0,   1, 0, 0, 0, 12'd3, 16'h1003, 13'd3,    1, 16'hBEEF);
    tbl[10] = mk(0, 1, 1, 12'd0, 16'h0000, 1, 16'h1004, 0,   1, 0, 0, 0, 12'd4, 16'h1004, 13'd4,    1, 16'hBEEF);
    tbl[11] = mk(0, 1, 1, 12'd0, 16'h0000, 1, 16'h2000, 1,   0, 0, 1, 1, 12'd0, 16'h0000, 13'd5,    1, 16'hBEEF);
    tbl[12] = mk(0, 1, 1, 12'd0, 16'h0000, 1, 16'h2000, 0,   1, 0, 0, 0, 12'd0, 16'h2000, 13'd0,    1, 16'hBEEF);
    tbl[13] = mk(0, 1, 1, 12'd0, 16'h0000, 0, 16'h0000, 0,   1, 0, 1, 1, 12'd0, 16'h0000, 13'd1,    1, 16'hBEEF);

    // Reset state, with a logger request already pending.
    rst = 1'b1; smem_ext = 1'b0; smem_cen = 1'b1; smem_wen = 1'b1;
    smem_addr = '0; smem_wdata = '0; log_valid = 1'b1; log_data = 16'h5555; log_clear = 1'b0;
    #1;
    chk("rst_mem_cen", mem_cen, 1);
    chk("rst_mem_wen", mem_wen, 1);
    chk("rst_ready", log_ready, 0);
    chk("rst_grant", ext_grant, 0);
    chk("rst_count", log_count, 0);
    chk("rst_full", log_full, 0);
    chk("rst_rdata", smem_rdata, 0);

    @(negedge clk); rst = 1'b0; log_valid = 1'b0; #1;
    chk("rel_ready", log_ready, 1);
    chk("rel_mem_cen", mem_cen, 1);

    // Test 1: fill the whole SRAM from the logger.
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk); log_valid = 1'b1; log_data = 16'(i) ^ 16'hA5A5; #1;
      chk("fill_ready", log_ready, 1);
      chk("fill_cen", mem_cen, 0);
      chk("fill_wen", mem_wen, 0);
      chk("fill_addr", mem_addr, 32'(i));
      chk("fill_wdata", mem_wdata, 32'(16'(i) ^ 16'hA5A5));
      chk("fill_count", log_count, 32'(i));
    end
    @(negedge clk); #1;
    chk("full_count", log_count, 4096);
    chk("full_flag", log_full, 1);
    chk("full_ready", log_ready, 0);
    chk("full_no_write", mem_cen, 1);

    // Test 2: switch to EXT and read everything back.
    @(negedge clk); log_valid = 1'b0; smem_ext = 1'b1; #1;
    chk("sw_grant_log", ext_grant, 0);
    chk("sw_cen_log", mem_cen, 1);
    @(negedge clk); smem_cen = 1'b0; smem_wen = 1'b1; smem_addr = 12'd5; #1;
    chk("turn_grant", ext_grant, 0);
    chk("turn_cen", mem_cen, 1);
    for (int k = 0; k < 4096; k++) begin
      @(negedge clk); smem_addr = 12'(k); #1;
      chk("sweep_grant", ext_grant, 1);
      chk("sweep_cen", mem_cen, 0);
      chk("sweep_wen", mem_wen, 1);
      chk("sweep_addr", mem_addr, 32'(k));
      if (k == 0) chk("sweep_rdata0", smem_rdata, 0);
      else        chk("sweep_rdata", smem_rdata, 32'(16'(k - 1) ^ 16'hA5A5));
    end

    // Tests 4 and 5 as per-cycle vectors.
    for (int r = 0; r < 14; r++) begin
      @(negedge clk);
      smem_ext = tbl[r].ext; smem_cen = tbl[r].cen; smem_wen = tbl[r].wen;
      smem_addr = tbl[r].addr; smem_wdata = tbl[r].wdata;
      log_valid = tbl[r].lv; log_data = tbl[r].ld; log_clear = tbl[r].clr;
      #1;
      chk($sformatf("v%0d_ready", r), log_ready, tbl[r].e_ready);
      chk($sformatf("v%0d_grant", r), ext_grant, tbl[r].e_grant);
      chk($sformatf("v%0d_cen", r), mem_cen, tbl[r].e_mcen);
      chk($sformatf("v%0d_wen", r), mem_wen, tbl[r].e_mwen);
      chk($sformatf("v%0d_count", r), log_count, tbl[r].e_count);
      if (!tbl[r].e_mcen) begin
        chk($sformatf("v%0d_addr", r), mem_addr, tbl[r].e_maddr);
        chk($sformatf("v%0d_wdata", r), mem_wdata, tbl[r].e_mwdata);
      end
      if (tbl[r].chk_rd) chk($sformatf("v%0d_rdata", r), smem_rdata, tbl[r].e_rdata);
    end

    // Test 3: held logger word across TURN/EXT/TURN.
    @(negedge clk); log_clear = 1'b1; log_valid = 1'b0; #1;
    chk("t3_clr_count", log_count, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); log_clear = 1'b0; log_valid = 1'b1; log_data = 16'h3000 + 16'(i); #1;
      chk("t3_log_addr", mem_addr, 32'(i));
      chk("t3_log_count", log_count, 32'(i));
    end
    @(negedge clk); log_valid = 1'b0; smem_ext = 1'b1; #1;
    chk("t3_log_cen", mem_cen, 1);
    chk("t3_count10", log_count, 10);
    @(negedge clk); log_valid = 1'b1; log_data = 16'h3ABC; #1;
    chk("t3_turn1_ready", log_ready, 0);
    chk("t3_turn1_cen", mem_cen, 1);
    @(negedge clk); smem_ext = 1'b0; #1;
    chk("t3_ext_ready", log_ready, 0);
    chk("t3_ext_grant", ext_grant, 1);
    @(negedge clk); #1;
    chk("t3_turn2_ready", log_ready, 0);
    chk("t3_turn2_grant", ext_grant, 0);
    chk("t3_turn2_cen", mem_cen, 1);
    @(negedge clk); #1;
    chk("t3_back_cen", mem_cen, 0);
    chk("t3_back_addr", mem_addr, 10);
    chk("t3_back_wdata", mem_wdata, 16'h3ABC);
    // Ext rising alongside a valid log word: the word is still accepted.
    @(negedge clk); log_data = 16'h3DEF; smem_ext = 1'b1; #1;
    chk("t3_count11", log_count, 11);
    chk("sim_ready", log_ready, 1);
    chk("sim_addr", mem_addr, 11);
    @(negedge clk); log_valid = 1'b0; #1;
    chk("sim_count", log_count, 12);
    chk("sim_turn_grant", ext_grant, 0);
    @(negedge clk); #1;
    chk("sim_ext_grant", ext_grant, 1);

    // Test 6: asynchronous reset in the middle of a read sweep.
    @(negedge clk); smem_cen = 1'b0; smem_wen = 1'b1; smem_addr = 12'd2; #1;
    chk("t6_cen", mem_cen, 0);
    @(negedge clk); smem_addr = 12'd3; #1;
    chk("t6_rdata2", smem_rdata, 16'h3002);
    @(negedge clk); smem_addr = 12'd4; log_valid = 1'b1; #1;
    chk("t6_rdata3", smem_rdata, 16'h3003);
    rst = 1'b1; #1;
    chk("t6_rst_cen", mem_cen, 1);
    chk("t6_rst_grant", ext_grant, 0);
    chk("t6_rst_rdata", smem_rdata, 0);
    chk("t6_rst_ready", log_ready, 0);
    chk("t6_rst_count", log_count, 0);
    @(negedge clk); rst = 1'b0; smem_ext = 1'b0; smem_cen = 1'b1; log_valid = 1'b0; #1;
    chk("t6_rel_grant", ext_grant, 0);
    chk("t6_rel_ready", log_ready, 1);
    @(negedge clk); #1;
    chk("t6_log_grant", ext_grant, 0);
    chk("t6_log_ready", log_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
